// File: rtl/uart_pkg.sv
// Shared UART types and default sizes for the receive path.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, plus a rising-edge pulse.
// Latency: q_o follows d_i after 2 clk_i edges; rise_o is high for the cycle after that.
// Backpressure: none; one pulse per rising edge of d_i, however long d_i stays high.
//
// Ports:
//   clk_i  - sampling clock
//   rst_i  - asynchronous active-high reset, clears all three flops
//   d_i    - asynchronous input level
//   q_o    - synchronised level (s2)
//   rise_o - one-cycle pulse on a 0->1 transition of the synchronised level
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic s1_q, s2_q, s3_q;

    // s1 may go metastable; s2 is the first flop safe to use; s3 is the
    // previous value of s2, kept only for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign q_o    = s2_q;
    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: captures each byte the UART receiver completes and presents it FWFT.
// Latency: save_i rising before edge N writes at edge N+2; data_o/count_o update after it.
// Backpressure: none towards the receiver; a byte arriving while full is dropped and overrun_o latches.
//
// Ports:
//   clk_i, rst_i  - system clock, asynchronous active-high reset
//   save_i        - byte-complete level from the receiver (asynchronous)
//   data_i        - received byte, stable while save_i is high
//   rd_en_i       - pop the head entry at the next edge (ignored when empty)
//   clr_ovr_i     - clear the sticky overrun flag
//   data_o        - head entry; holds the last head value while empty
//   empty_o, full_o, count_o - occupancy
//   overrun_o     - sticky: a byte arrived while the FIFO was full
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_W,
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             save_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             rd_en_i,
    input  logic             clr_ovr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o,
    output logic             overrun_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] last_q, last_d;

    logic save_lvl, save_rise;
    logic wr_pulse, wr_ok, rd_ok;

    sync_edge_det u_save_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (save_i),
        .q_o    (save_lvl),
        .rise_o (save_rise)
    );

    // rise_o already implies the synchronised level is high; both terms are
    // kept so the write qualification reads directly as "level just went high".
    assign wr_pulse = save_rise & save_lvl;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    // A write while full is still accepted if a read frees the head slot at
    // the same edge (write and read pointers coincide when full).
    assign rd_ok = rd_en_i & ~empty_o;
    assign wr_ok = wr_pulse & (~full_o | rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovr_d    = ovr_q;
        last_d   = last_q;

        if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);

        if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
        else if (rd_ok && !wr_ok) count_d = count_q - CW'(1);

        // Set has priority over clear.
        if (clr_ovr_i)           ovr_d = 1'b0;
        if (wr_pulse && !wr_ok)  ovr_d = 1'b1;

        // Track the current head so data_o can keep showing it after the
        // FIFO drains.
        if (!empty_o) last_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            last_q   <= last_d;
        end
    end

    // Storage is deliberately not reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o    = empty_o ? last_q : mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = UART_FIFO_DEPTH;
    localparam int CW    = $clog2(DEPTH + 1);

    logic       clk_i     = 1'b0;
    logic       rst_i     = 1'b0;
    logic       save_i    = 1'b0;
    uart_byte_t data_i    = '0;
    logic       rd_en_i   = 1'b0;
    logic       clr_ovr_i = 1'b0;
    uart_byte_t data_o;
    logic       empty_o, full_o, overrun_o;
    logic [CW-1:0] count_o;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .save_i    (save_i),
        .data_i    (data_i),
        .rd_en_i   (rd_en_i),
        .clr_ovr_i (clr_ovr_i),
        .data_o    (data_o),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .count_o   (count_o),
        .overrun_o (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus only: one complete save_i pulse, returns on a negedge with the
    // edge detector re-armed.
    task automatic push_byte(input uart_byte_t b);
        @(negedge clk_i);
        data_i = b;
        save_i = 1'b1;
        repeat (3) @(negedge clk_i);
        save_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    // Stimulus only: one-cycle rd_en_i, called and returning on a negedge.
    task automatic pop_byte();
        rd_en_i = 1'b1;
        @(negedge clk_i);
        rd_en_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full_o); end
        checks++; if (count_o !== CW'(0)) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk_i);
        data_i = 8'hA5;
        save_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            if (i == 2) begin
                checks++; if (count_o !== CW'(0)) begin errors++; $display("FAIL single_early_count got %0d want 0", count_o); end
            end
            if (i == 3) begin
                checks++; if (count_o !== CW'(1)) begin errors++; $display("FAIL single_count got %0d want 1", count_o); end
                checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", data_o); end
            end
            if (i == 20) begin
                checks++; if (count_o !== CW'(1)) begin errors++; $display("FAIL single_onewrite got %0d want 1", count_o); end
            end
        end
        save_i = 1'b0;
        repeat (3) @(negedge clk_i);
        pop_byte();
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL single_pop_empty got %b want 1", empty_o); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < 16; i++) push_byte(uart_byte_t'(i));
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full_o); end
        checks++; if (count_o !== CW'(16)) begin errors++; $display("FAIL fill_count got %0d want 16", count_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL fill_no_ovr got %b want 0", overrun_o); end
        push_byte(8'hFF);
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun_o); end
        checks++; if (count_o !== CW'(16)) begin errors++; $display("FAIL ovr_count got %0d want 16", count_o); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (data_o !== uart_byte_t'(i)) begin errors++; $display("FAIL fill_order[%0d] got %h want %h", i, data_o, uart_byte_t'(i)); end
            pop_byte();
        end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty_o); end
        checks++; if (data_o !== 8'h0F) begin errors++; $display("FAIL drain_hold got %h want 0f", data_o); end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun_o); end
        clr_ovr_i = 1'b1;
        @(negedge clk_i);
        clr_ovr_i = 1'b0;
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun_o); end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 16; i++) push_byte(uart_byte_t'(i));
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL simul_prefull got %b want 1", full_o); end
        @(negedge clk_i);
        data_i = 8'h10;
        save_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rd_en_i = 1'b1;          // same cycle as the write pulse
        @(negedge clk_i);
        rd_en_i = 1'b0;
        checks++; if (count_o !== CW'(16)) begin errors++; $display("FAIL simul_count got %0d want 16", count_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL simul_ovr got %b want 0", overrun_o); end
        checks++; if (data_o !== 8'h01) begin errors++; $display("FAIL simul_head got %h want 01", data_o); end
        save_i = 1'b0;
        repeat (3) @(negedge clk_i);
        for (int i = 1; i <= 16; i++) begin
            checks++; if (data_o !== uart_byte_t'(i)) begin errors++; $display("FAIL simul_order[%0d] got %h want %h", i, data_o, uart_byte_t'(i)); end
            pop_byte();
        end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL simul_empty got %b want 1", empty_o); end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 4; k++) push_byte(uart_byte_t'(8'h30 + 4 * r + k));
            checks++; if (count_o !== CW'(4)) begin errors++; $display("FAIL wrap_count[%0d] got %0d want 4", r, count_o); end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (data_o !== uart_byte_t'(8'h30 + 4 * r + k)) begin
                    errors++;
                    $display("FAIL wrap_data[%0d] got %h want %h", 4 * r + k, data_o, uart_byte_t'(8'h30 + 4 * r + k));
                end
                pop_byte();
            end
        end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b want 1", empty_o); end
    endtask

    task automatic test_empty_read_reset();
        pop_byte();
        checks++; if (count_o !== CW'(0)) begin errors++; $display("FAIL rd_empty_count got %0d want 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rd_empty_flag got %b want 1", empty_o); end
        checks++; if (data_o !== 8'h57) begin errors++; $display("FAIL rd_empty_data got %h want 57", data_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rd_empty_ovr got %b want 0", overrun_o); end
        for (int i = 0; i < 5; i++) push_byte(uart_byte_t'(8'h60 + i));
        checks++; if (count_o !== CW'(5)) begin errors++; $display("FAIL pre_reset_count got %0d want 5", count_o); end
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        data_i = 8'h99;
        save_i = 1'b1;
        #1;
        checks++; if (count_o !== CW'(0)) begin errors++; $display("FAIL midrst_count got %0d want 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b want 1", empty_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", data_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            if (i == 2) begin
                checks++; if (count_o !== CW'(0)) begin errors++; $display("FAIL rel_early_count got %0d want 0", count_o); end
            end
            if (i == 3) begin
                checks++; if (count_o !== CW'(1)) begin errors++; $display("FAIL rel_count got %0d want 1", count_o); end
                checks++; if (data_o !== 8'h99) begin errors++; $display("FAIL rel_data got %h want 99", data_o); end
            end
            if (i == 10) begin
                checks++; if (count_o !== CW'(1)) begin errors++; $display("FAIL rel_onewrite got %0d want 1", count_o); end
            end
        end
        save_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overrun();
        test_simul_full();
        test_wrap();
        test_empty_read_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
